uart_tx_arbiter: RTL and testbench

Round-robin controller that shares one UART transmit engine between NUM_REQ byte requesters.
- Accepts one byte at a time from a requester over a valid/ready handshake.
- Latches the byte, launches the engine with a start pulse, then tracks the engine's busy flag until the frame completes.
- Flags an error if the engine never acknowledges a launch.
- Sits between client blocks (register bank, debug/log sources) and the TX serializer.

---
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX engine among NUM_REQ byte requesters.
// Defining UART_TX_ARB_GAP_EN adds a GAP_CYCLES idle state between frames.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int BYTESIZES     = 8,
    parameter int START_TIMEOUT = 1024,
    parameter int GAP_CYCLES    = 16,
    localparam int IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clock,
    input  logic                           nreset,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    input  logic [NUM_REQ*BYTESIZES-1:0]   req_data_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    output logic                           tx_start_out,
    output logic [BYTESIZES-1:0]           tx_data_out,
    input  logic                           tx_busy_in,
    output logic [IW-1:0]                  grant_id_out,
    output logic                           busy_out,
    output logic                           timeout_err_out
);
    localparam int CW = $clog2(((START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES) + 1);

`ifdef UART_TX_ARB_GAP_EN
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
`endif

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        ptr_q, ptr_d, grant_q, grant_d, win;
    logic [BYTESIZES-1:0] data_q, data_d, win_data;
    logic                 accept, timeout, counting;

    // Second pass overrides the first, so indices above the pointer win before wrapping.
    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid_in[i] && IW'(i) <= ptr_q) win = IW'(i);
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid_in[i] && IW'(i) > ptr_q) win = IW'(i);
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win == IW'(i)) win_data = req_data_in[i*BYTESIZES +: BYTESIZES];
    end

    assign accept  = state_q == IDLE && |req_valid_in;
    assign timeout = state_q == WAIT_BUSY && !tx_busy_in && cnt_q == CW'(START_TIMEOUT - 1);
`ifdef UART_TX_ARB_GAP_EN
    assign counting = state_q == WAIT_BUSY || state_q == GAP;
`else
    assign counting = state_q == WAIT_BUSY;
`endif

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy_in) state_d = WAIT_DONE;
                       else if (timeout) state_d = IDLE;
`ifdef UART_TX_ARB_GAP_EN
            WAIT_DONE: if (!tx_busy_in) state_d = GAP;
            GAP:       if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = IDLE;
`else
            WAIT_DONE: if (!tx_busy_in) state_d = IDLE;
`endif
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = counting ? cnt_q + CW'(1) : '0;
        ptr_d   = accept ? win : ptr_q;
        grant_d = accept ? win : grant_q;
        data_d  = accept ? win_data : data_q;
    end

    // Ready is gated by nreset so no requester sees a transfer while the block is held in reset.
    always_comb begin
        req_ready_out = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready_out[i] = nreset && accept && win == IW'(i);
        tx_start_out    = state_q == LAUNCH;
        busy_out        = state_q != IDLE;
        timeout_err_out = timeout;
        tx_data_out     = data_q;
        grant_id_out    = grant_q;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized bench for uart_tx_arbiter against a transaction-level model.
// The model predicts accept/launch/timeout cycles from frame timing, not from the RTL state machine.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int B  = 8;
    localparam int ST = 8;
    localparam int GC = 4;
`ifdef UART_TX_ARB_GAP_EN
    localparam int GAP = GC;
`else
    localparam int GAP = 0;
`endif

    logic           clock = 0, nreset = 0;
    logic [N-1:0]   req_valid_in = '0, req_ready_out;
    logic [N*B-1:0] req_data_in = '0;
    logic           tx_start_out, tx_busy_in = 0, busy_out, timeout_err_out;
    logic [B-1:0]   tx_data_out;
    logic [1:0]     grant_id_out;

    int total = 0, bad = 0;
    int cyc = 0, free_at = 0, start_at = -1, to_at = -1, rise_at = -1, fall_at = -1;
    int last_rr = N - 1, exp_grant = 0, n_to = 0;
    logic [B-1:0] exp_data = '0;
    bit pend [N];
    logic [B-1:0] pdata [N];
    int eng_mode = 1;
    int obs [$];
    bit saw1 = 0;

    always #5 clock = ~clock;

    uart_tx_arbiter #(.NUM_REQ(N), .BYTESIZES(B), .START_TIMEOUT(ST), .GAP_CYCLES(GC)) dut (
        .clock(clock), .nreset(nreset), .req_valid_in(req_valid_in), .req_data_in(req_data_in),
        .req_ready_out(req_ready_out), .tx_start_out(tx_start_out), .tx_data_out(tx_data_out),
        .tx_busy_in(tx_busy_in), .grant_id_out(grant_id_out), .busy_out(busy_out),
        .timeout_err_out(timeout_err_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Engine mode 0: random latency/length, sometimes silent; 1: 10-cycle frame; 2: never busy.
    task automatic accept(input int w);
        int d, len;
        bit resp;
        exp_data  = pdata[w];
        exp_grant = w;
        last_rr   = w;
        pend[w]   = 0;
        start_at  = cyc + 1;
        resp = eng_mode == 1 || (eng_mode == 0 && $urandom_range(4) != 0);
        d    = eng_mode == 1 ? 1 : int'($urandom_range(ST));
        len  = eng_mode == 1 ? 10 : int'($urandom_range(12, d == 0 ? 2 : 1));
        if (resp) begin
            rise_at = start_at + d;
            fall_at = rise_at + len;
            free_at = fall_at + 1 + GAP;
            to_at   = -1;
        end else begin
            rise_at = -1;
            fall_at = -1;
            to_at   = start_at + ST;
            free_at = to_at + 1;
        end
    endtask

    task automatic step();
        int w;
        bit idle;
        logic [N-1:0] er;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            req_valid_in[i] = pend[i];
            req_data_in[i*B +: B] = pdata[i];
        end
        tx_busy_in = cyc >= rise_at && cyc < fall_at;
        #1;
        idle = cyc >= free_at;
        w = -1;
        if (idle)
            for (int k = 1; k <= N; k++)
                if (w < 0 && pend[(last_rr + k) % N]) w = (last_rr + k) % N;
        er = w >= 0 ? N'(1) << w : '0;
        check("ready", req_ready_out, er);
        check("start", tx_start_out, cyc == start_at);
        check("timeout", timeout_err_out, cyc == to_at);
        check("busy", busy_out, !idle);
        check("data", tx_data_out, exp_data);
        check("grant", grant_id_out, exp_grant);
        if (timeout_err_out) n_to++;
        for (int i = 0; i < N; i++)
            if (req_ready_out[i]) begin
                obs.push_back(i);
                if (i == 1) saw1 = 1;
            end
        if (w >= 0) accept(w);
        cyc++;
    endtask

    task automatic gen(input int raise_pct, input bit drop_en);
        for (int i = 0; i < N; i++)
            if (pend[i]) begin
                if (drop_en && $urandom_range(15) == 0) pend[i] = 0;
            end else if (int'($urandom_range(99)) < raise_pct) begin
                pend[i]  = 1;
                pdata[i] = B'($urandom);
            end
    endtask

    task automatic do_reset();
        nreset = 0;
        #1;
        check("rst_ready", req_ready_out, 0);
        check("rst_start", tx_start_out, 0);
        check("rst_data", tx_data_out, 0);
        check("rst_grant", grant_id_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_timeout", timeout_err_out, 0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        req_valid_in = '0;
        tx_busy_in   = 0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        nreset  = 1;
        free_at = cyc;
        start_at = -1; to_at = -1; rise_at = -1; fall_at = -1;
        last_rr = N - 1; exp_data = '0; exp_grant = 0;
        obs.delete();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && cyc < free_at; i++) step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i]  = 0;
            pdata[i] = '0;
        end
        req_valid_in = '1;
        do_reset();

        eng_mode = 1;
        pend[2]  = 1;
        pdata[2] = 8'hA5;
        step();
        check("a5_accept", obs.size() > 0 ? obs[0] : 99, 2);
        step();
        check("a5_start", tx_start_out, 1);
        check("a5_data", tx_data_out, 8'hA5);
        check("a5_gid", grant_id_out, 2);
        wait_idle();

        do_reset();
        for (int i = 0; i < 200 && obs.size() < 5; i++) begin
            gen(100, 0);
            step();
        end
        for (int k = 0; k < 5; k++) check("rr_order", k < obs.size() ? obs[k] : 99, k % N);

        for (int i = 0; i < 50 && !(cyc - 1 >= rise_at + 2 && cyc - 1 < fall_at); i++) begin
            gen(100, 0);
            step();
        end
        do_reset();
        gen(100, 0);
        step();
        check("rst_first", obs.size() > 0 ? obs[0] : 99, 0);
        for (int i = 0; i < N; i++) pend[i] = 0;
        wait_idle();

        eng_mode = 2;
        n_to     = 0;
        pend[1]  = 1;
        pdata[1] = 8'h3C;
        repeat (ST + 6) step();
        check("to_seen", n_to, 1);
        eng_mode = 1;
        pend[0]  = 1;
        pdata[0] = 8'h5A;
        repeat (4) step();
        check("after_to", obs.size() > 0 ? obs[obs.size()-1] : 99, 0);
        wait_idle();

        pend[0] = 1;
        step();
        saw1 = 0;
        pend[1] = 1;
        pend[3] = 1;
        repeat (3) step();
        pend[1] = 0;
        for (int i = 0; i < 40 && pend[3]; i++) step();
        check("drop_r1", saw1, 0);
        check("drop_r3", obs.size() > 0 ? obs[obs.size()-1] : 99, 3);
        wait_idle();

        eng_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            gen(30, 1);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
